reg_peek_display: RTL and testbench

//   Multi-channel register viewer for the processor datapath debug board.
//   - Selects one of NUM_CH datapath registers (RA, RB, RZ, RM, RY, ...).
//   - Snapshots the selected register on a debounced pushbutton press, or scrolls through channels automatically.
//   - Drives DIGITS active-low seven-segment displays from the held snapshot.

---
 rtl/reg_peek_pkg.sv | 31 +++
 rtl/peek_debounce.sv | 45 ++++
 rtl/reg_peek_display.sv | 114 +++++++++++
 tb/tb_reg_peek_display.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_peek_pkg.sv
// Shared constants and the nibble-to-segment decoder for the register viewer.
// Segment patterns are active low, ordered gfedcba.
package reg_peek_pkg;

    localparam logic [3:0] ERR_NIBBLE = 4'hE;
    localparam logic [6:0] SEG_E      = 7'b0000110;

    function automatic logic [6:0] hex_to_seg_n(input logic [3:0] nibble);
        logic [6:0] seg;
        case (nibble)
            4'h0:    seg = 7'b1000000;
            4'h1:    seg = 7'b1111001;
            4'h2:    seg = 7'b0100100;
            4'h3:    seg = 7'b0110000;
            4'h4:    seg = 7'b0011001;
            4'h5:    seg = 7'b0010010;
            4'h6:    seg = 7'b0000010;
            4'h7:    seg = 7'b1111000;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0010000;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b0000011;
            4'hC:    seg = 7'b1000110;
            4'hD:    seg = 7'b0100001;
            4'hE:    seg = SEG_E;
            default: seg = 7'b0001110;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/peek_debounce.sv
// Pushbutton conditioning: 2-flop synchroniser, stability counter and
// a one-cycle press pulse on the debounced falling edge.
module peek_debounce #(
    parameter int unsigned DEBOUNCE_CYC = 50000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_n_async,
    output logic level,
    output logic press
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYC + 1);

    logic             sync_1;
    logic             sync_2;
    logic [CNT_W-1:0] stable_cnt;
    logic             settle_c;

    // Last of the required consecutive differing cycles
    assign settle_c = (sync_2 != level) && (stable_cnt == CNT_W'(DEBOUNCE_CYC - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_1     <= 1'b1;
            sync_2     <= 1'b1;
            level      <= 1'b1;
            stable_cnt <= '0;
            press      <= 1'b0;
        end else begin
            sync_1 <= btn_n_async;
            sync_2 <= sync_1;
            press  <= settle_c && level;
            if (sync_2 == level) begin
                stable_cnt <= '0;
            end else if (settle_c) begin
                level      <= sync_2;
                stable_cnt <= '0;
            end else begin
                stable_cnt <= stable_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/reg_peek_display.sv
// Multi-channel register viewer: snapshots a datapath register on a debounced
// press or auto-scrolls through channels, driving active-low 7-segment digits.
module reg_peek_display
    import reg_peek_pkg::*;
#(
    parameter  int unsigned DATA_W       = 32,
    parameter  int unsigned NUM_CH       = 5,
    parameter  int unsigned DEBOUNCE_CYC = 50000,
    parameter  int unsigned SCROLL_CYC   = 50000000,
    localparam int unsigned SEL_W        = $clog2(NUM_CH),
    localparam int unsigned DIGITS       = DATA_W / 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_CH*DATA_W-1:0] ch_data,
    input  logic [SEL_W-1:0]         ch_sel,
    input  logic                     peek_n,
    input  logic                     mode_auto,
    input  logic                     freeze,
    output logic [7*DIGITS-1:0]      hex_out,
    output logic [SEL_W-1:0]         cur_ch,
    output logic                     sel_err
);

    localparam int unsigned SCNT_W = $clog2(SCROLL_CYC + 1);

    logic [SEL_W-1:0]    sel_meta;
    logic [SEL_W-1:0]    sel_sync;
    logic                press;
    logic                btn_level_unused;
    logic [DATA_W-1:0]   snapshot;
    logic [SCNT_W-1:0]   scroll_cnt;
    logic [DATA_W-1:0]   sel_word_c;
    logic [DATA_W-1:0]   cur_word_c;
    logic                sel_ok_c;
    logic                wrap_c;
    logic [SEL_W-1:0]    cur_next_c;
    logic [7*DIGITS-1:0] seg_c;

    function automatic logic [DATA_W-1:0] channel(input logic [NUM_CH*DATA_W-1:0] data,
                                                  input logic [SEL_W-1:0] idx);
        logic [DATA_W-1:0] word;
        word = '0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            if (idx == SEL_W'(k)) word = data[k*DATA_W +: DATA_W];
        end
        return word;
    endfunction

    peek_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_debounce (
        .clk         (clk),
        .reset       (reset),
        .btn_n_async (peek_n),
        .level       (btn_level_unused),
        .press       (press)
    );

    always_comb begin
        sel_word_c = channel(ch_data, sel_sync);
        cur_word_c = channel(ch_data, cur_ch);
        sel_ok_c   = 32'(sel_sync) < NUM_CH;
        wrap_c     = scroll_cnt == SCNT_W'(SCROLL_CYC - 1);
        cur_next_c = (cur_ch == SEL_W'(NUM_CH - 1)) ? '0 : cur_ch + SEL_W'(1);
    end

    // Manual mode keeps the scroll counter at zero so auto starts a fresh period
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sel_meta   <= '0;
            sel_sync   <= '0;
            snapshot   <= {DIGITS{ERR_NIBBLE}};
            cur_ch     <= '0;
            sel_err    <= 1'b0;
            scroll_cnt <= '0;
        end else begin
            sel_meta <= ch_sel;
            sel_sync <= sel_meta;
            if (!mode_auto) begin
                scroll_cnt <= '0;
                if (press && !freeze) begin
                    if (sel_ok_c) begin
                        snapshot <= sel_word_c;
                        cur_ch   <= sel_sync;
                        sel_err  <= 1'b0;
                    end else begin
                        snapshot <= {DIGITS{ERR_NIBBLE}};
                        sel_err  <= 1'b1;
                    end
                end
            end else begin
                sel_err <= 1'b0;
                if (!freeze) begin
                    snapshot <= cur_word_c;
                    if (press || wrap_c) begin
                        cur_ch     <= cur_next_c;
                        scroll_cnt <= '0;
                    end else begin
                        scroll_cnt <= scroll_cnt + SCNT_W'(1);
                    end
                end
            end
        end
    end

    for (genvar d = 0; d < DIGITS; d++) begin : g_digit
        assign seg_c[7*d +: 7] = hex_to_seg_n(snapshot[4*d +: 4]);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) hex_out <= {DIGITS{SEG_E}};
        else       hex_out <= seg_c;
    end

endmodule

// File: tb/tb_reg_peek_display.sv
// Self-checking bench for reg_peek_display: directed sequences, a vector table
// and randomized stimulus against a cycle-level behavioural model.
module tb_reg_peek_display;

    localparam int unsigned DATA_W       = 32;
    localparam int unsigned NUM_CH       = 5;
    localparam int unsigned DEBOUNCE_CYC = 4;
    localparam int unsigned SCROLL_CYC   = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic [159:0] ch_data;
    logic [2:0]   ch_sel;
    logic         peek_n;
    logic         mode_auto;
    logic         freeze;
    logic [55:0]  hex_out;
    logic [2:0]   cur_ch;
    logic         sel_err;

    int total  = 0;
    int passed = 0;
    int press_seen = 0;

    reg_peek_display #(
        .DATA_W(DATA_W), .NUM_CH(NUM_CH), .DEBOUNCE_CYC(DEBOUNCE_CYC), .SCROLL_CYC(SCROLL_CYC)
    ) dut (
        .clk(clk), .reset(reset), .ch_data(ch_data), .ch_sel(ch_sel), .peek_n(peek_n),
        .mode_auto(mode_auto), .freeze(freeze), .hex_out(hex_out), .cur_ch(cur_ch), .sel_err(sel_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (dut.u_debounce.press === 1'b1) press_seen++;

    // Active-high segment patterns, gfedcba
    function automatic logic [6:0] seg_lit(input logic [3:0] n);
        case (n)
            4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
            4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
            4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
            4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
        endcase
    endfunction

    function automatic logic [55:0] seg_word(input logic [31:0] v);
        logic [55:0] w;
        for (int k = 0; k < 8; k++) w[7*k +: 7] = ~seg_lit(v[4*k +: 4]);
        return w;
    endfunction

    // Behavioural model: debounced level flips once the last DEBOUNCE_CYC
    // synchronised samples (two cycles old) all disagree with it.
    bit          btn_h[$];
    int          sel_h[$];
    bit          m_lvl, m_press, pr_now, run_ok;
    int          m_cur, m_ticks, sel_now;
    bit          m_err;
    logic [31:0] m_snap, snap_old;
    logic [55:0] m_hex;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_snap = 32'hEEEEEEEE; m_hex = seg_word(32'hEEEEEEEE);
            m_cur = 0; m_err = 0; m_ticks = 0; m_press = 0; m_lvl = 1;
            btn_h.delete(); sel_h.delete();
            for (int i = 0; i < 6; i++) btn_h.push_back(1'b1);
            for (int i = 0; i < 3; i++) sel_h.push_back(0);
        end else begin
            pr_now   = m_press;
            snap_old = m_snap;
            btn_h.push_front(peek_n);
            sel_h.push_front(int'(ch_sel));
            while (btn_h.size() > 6) void'(btn_h.pop_back());
            while (sel_h.size() > 3) void'(sel_h.pop_back());
            run_ok = 1;
            for (int i = 2; i < 2 + DEBOUNCE_CYC; i++) if (btn_h[i] == m_lvl) run_ok = 0;
            m_press = run_ok & m_lvl;
            if (run_ok) m_lvl = ~m_lvl;
            sel_now = sel_h[2];
            if (!mode_auto) begin
                m_ticks = 0;
                if (pr_now && !freeze) begin
                    if (sel_now < NUM_CH) begin
                        m_snap = ch_data[sel_now*32 +: 32]; m_cur = sel_now; m_err = 0;
                    end else begin
                        m_snap = 32'hEEEEEEEE; m_err = 1;
                    end
                end
            end else begin
                m_err = 0;
                if (!freeze) begin
                    m_snap = ch_data[m_cur*32 +: 32];
                    if (pr_now || m_ticks == SCROLL_CYC - 1) begin
                        m_cur = (m_cur + 1) % NUM_CH; m_ticks = 0;
                    end else begin
                        m_ticks++;
                    end
                end
            end
            m_hex = seg_word(snap_old);
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("model_hex", 64'(hex_out), 64'(m_hex));
            chk("model_cur", 64'(cur_ch), 64'(m_cur));
            chk("model_err", 64'(sel_err), 64'(m_err));
        end
    endtask

    task automatic press_btn(input int sel);
        ch_sel = 3'(sel); peek_n = 1'b0; step(10);
        peek_n = 1'b1; step(10);
    endtask

    typedef struct {
        int          sel;
        logic [31:0] val;
        int          exp_cur;
        bit          exp_err;
        logic [31:0] exp_snap;
    } vec_t;

    vec_t        tbl[6];
    int          p0, fcur;
    logic [55:0] fhex;
    int          idx;

    initial begin
        tbl[0] = '{3, 32'h0F1E2D3C, 3, 1'b0, 32'h0F1E2D3C};
        tbl[1] = '{7, 32'h0,        3, 1'b1, 32'hEEEEEEEE};
        tbl[2] = '{0, 32'h89ABCDEF, 0, 1'b0, 32'h89ABCDEF};
        tbl[3] = '{5, 32'h0,        0, 1'b1, 32'hEEEEEEEE};
        tbl[4] = '{4, 32'h76543210, 4, 1'b0, 32'h76543210};
        tbl[5] = '{1, 32'h55AA33CC, 1, 1'b0, 32'h55AA33CC};

        reset = 1'b1; peek_n = 1'b1; ch_sel = '0; mode_auto = 1'b0; freeze = 1'b0;
        ch_data = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        step(3);
        reset = 1'b0;
        step(2);
        chk("reset_hex", 64'(hex_out), 64'({8{7'b0000110}}));
        chk("reset_cur", 64'(cur_ch), 64'(0));
        chk("reset_err", 64'(sel_err), 64'(0));

        // Snapshot load and independence from later channel changes
        ch_data[64 +: 32] = 32'h1234ABCD; ch_sel = 3'd2; peek_n = 1'b0;
        step(10);
        chk("peek_hex", 64'(hex_out), 64'(seg_word(32'h1234ABCD)));
        chk("peek_cur", 64'(cur_ch), 64'(2));
        ch_data[64 +: 32] = 32'h00000000;
        step(3);
        chk("hold_hex", 64'(hex_out), 64'(seg_word(32'h1234ABCD)));
        peek_n = 1'b1; step(10);

        // Bouncing button yields exactly one press
        ch_data[32 +: 32] = 32'hCAFEF00D; ch_sel = 3'd1; p0 = press_seen;
        for (int i = 0; i < 10; i++) begin
            peek_n = (i % 2 == 0) ? 1'b0 : 1'b1; step(2);
        end
        peek_n = 1'b0; step(10);
        chk("bounce_presses", 64'(press_seen - p0), 64'(1));
        chk("bounce_hex", 64'(hex_out), 64'(seg_word(32'hCAFEF00D)));
        peek_n = 1'b1; step(10);

        // Out-of-range select, then recovery
        press_btn(6);
        chk("selerr_err", 64'(sel_err), 64'(1));
        chk("selerr_hex", 64'(hex_out), 64'({8{7'b0000110}}));
        chk("selerr_cur", 64'(cur_ch), 64'(1));
        ch_data[0 +: 32] = 32'h600DBEEF;
        press_btn(0);
        chk("recover_err", 64'(sel_err), 64'(0));
        chk("recover_hex", 64'(hex_out), 64'(seg_word(32'h600DBEEF)));

        for (int i = 0; i < 6; i++) begin
            if (tbl[i].sel < NUM_CH) ch_data[tbl[i].sel*32 +: 32] = tbl[i].val;
            press_btn(tbl[i].sel);
            chk("tbl_hex", 64'(hex_out), 64'(seg_word(tbl[i].exp_snap)));
            chk("tbl_cur", 64'(cur_ch), 64'(tbl[i].exp_cur));
            chk("tbl_err", 64'(sel_err), 64'(tbl[i].exp_err));
        end

        // Auto scroll from channel 3, press landing on a wrap cycle
        press_btn(3);
        mode_auto = 1'b1;
        step(4);  chk("auto_cur_a", 64'(cur_ch), 64'(3));
        step(8);  chk("auto_cur_b", 64'(cur_ch), 64'(4));
        step(8);  chk("auto_cur_c", 64'(cur_ch), 64'(0));
        step(5);  peek_n = 1'b0;
        step(3);  chk("auto_cur_d", 64'(cur_ch), 64'(1));
        step(6);  chk("wrap_press_cur", 64'(cur_ch), 64'(2));
        step(7);  chk("wrap_next_cur", 64'(cur_ch), 64'(3));
        peek_n = 1'b1; step(10);

        // Freeze in auto: nothing moves despite data changes and presses
        freeze = 1'b1; step(2);
        fcur = m_cur; fhex = m_hex;
        for (int i = 0; i < 5; i++) ch_data[i*32 +: 32] = $urandom();
        peek_n = 1'b0; step(12); peek_n = 1'b1; step(16);
        chk("freeze_cur", 64'(cur_ch), 64'(fcur));
        chk("freeze_hex", 64'(hex_out), 64'(fhex));

        // Reset in the middle of a debounce
        freeze = 1'b0; mode_auto = 1'b0; step(2);
        p0 = press_seen;
        peek_n = 1'b0; step(3);
        reset = 1'b1; peek_n = 1'b1; step(2);
        reset = 1'b0; step(1);
        chk("midrst_hex", 64'(hex_out), 64'({8{7'b0000110}}));
        chk("midrst_cur", 64'(cur_ch), 64'(0));
        chk("midrst_err", 64'(sel_err), 64'(0));
        step(20);
        chk("midrst_nopress", 64'(press_seen - p0), 64'(0));

        // Randomized traffic against the model
        for (int it = 0; it < 1500; it++) begin
            peek_n = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) ch_sel = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 24) == 0) mode_auto = ~mode_auto;
            if (freeze ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 19) == 0)) freeze = ~freeze;
            if ($urandom_range(0, 2) == 0) begin
                idx = int'($urandom_range(0, 4));
                ch_data[idx*32 +: 32] = $urandom();
            end
            step(int'($urandom_range(1, 12)));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
